// File: rtl/ram_seq_pkg.sv
// Shared widths, limits and state encoding for the RAM fill/scan sequencer.
package ram_seq_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    SCAN_RD    = 3'd2,
    SCAN_CAP   = 3'd3,
    SCAN_DWELL = 3'd4
  } state_t;

  // Fill pattern: base value plus the low nibble of the address, wrapping mod 16.
  function automatic logic [DATA_W-1:0] fill_word(input logic [DATA_W-1:0] base,
                                                  input logic [ADDR_W-1:0] a);
    return base + a[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that sets how long each scanned word stays on the display.
// Loading takes priority over decrementing. The counter stops at zero.
module dwell_timer #(
  parameter int         W        = 1,
  parameter logic [W-1:0] LOAD_VAL = '0
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] count;

  // Clear, then load, then decrement. There is no wrap below zero.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ram_sequencer.sv
// Sequencer for a 32x4 RAM. It has two operations:
// - FILL writes a seed-based pattern to all 32 words.
// - SCAN reads every word back and holds each one on the display outputs
//   for DWELL_CYCLES clocks.
// Start protocol: go is sampled as a level and is acted on only while busy=0.
// After a start is accepted, busy stays high until the block returns to IDLE.
// done pulses for one cycle when an operation completes normally.
// An abort or a reset never raises done.
module ram_sequencer
  import ram_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              go,
  input  logic              mode,
  input  logic              abort,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              dw_zero;
  logic              dw_clr;
  logic              dw_load;
  logic              dw_dec;

  // Dwell timer controls, decoded from the current state.
  // An abort clears the timer so that the next scan starts clean.
  always_comb begin
    dw_clr  = 1'b0;
    dw_load = 1'b0;
    dw_dec  = 1'b0;
    if (abort && (state != IDLE)) begin
      dw_clr = 1'b1;
    end else if (state == SCAN_CAP) begin
      dw_load = 1'b1;
    end else if ((state == SCAN_DWELL) && !dw_zero) begin
      dw_dec = 1'b1;
    end
  end

  dwell_timer #(
    .W        (DW_W),
    .LOAD_VAL (DWELL_LOAD)
  ) u_dwell (
    .clock  (clock),
    .resetn (resetn),
    .clr    (dw_clr),
    .load   (dw_load),
    .dec    (dw_dec),
    .zero   (dw_zero)
  );

  // Main FSM. Every output is registered here.
  // Abort outranks every other transition.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      address    <= '0;
      data       <= '0;
      wren       <= 1'b0;
      scan_addr  <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        wren  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go && !abort) begin
              addr_cnt <= '0;
              address  <= '0;
              busy     <= 1'b1;
              if (!mode) begin
                state      <= FILL;
                wren       <= 1'b1;
                data       <= fill_word(seed, '0);
                scan_valid <= 1'b0;
              end else begin
                state <= SCAN_RD;
                wren  <= 1'b0;
              end
            end
          end
          FILL: begin
            if (addr_cnt == LAST_ADDR) begin
              state <= IDLE;
              wren  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr_cnt <= addr_cnt + 5'd1;
              address  <= addr_cnt + 5'd1;
              data     <= fill_word(seed, addr_cnt + 5'd1);
            end
          end
          SCAN_RD: begin
            state <= SCAN_CAP;
          end
          SCAN_CAP: begin
            scan_data  <= q;
            scan_addr  <= addr_cnt;
            scan_valid <= 1'b1;
            state      <= SCAN_DWELL;
          end
          SCAN_DWELL: begin
            if (dw_zero) begin
              if (addr_cnt == LAST_ADDR) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                addr_cnt <= addr_cnt + 5'd1;
                address  <= addr_cnt + 5'd1;
                state    <= SCAN_RD;
              end
            end
          end
          default: begin
            state <= IDLE;
            wren  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer with a behavioural 32x4 RAM that has
// one cycle of read latency. Expected writes and expected scanned words
// are pushed to queues as each operation starts, and are popped as the
// DUT produces them.
module tb_ram_sequencer;
  import ram_seq_pkg::*;

  localparam int DWELL = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn, go, mode, abort;
  logic [3:0] seed, q;
  logic [4:0] address, scan_addr;
  logic [3:0] data, scan_data;
  logic       wren, scan_valid, busy, done;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ram_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clock      (clk),
    .resetn     (resetn),
    .go         (go),
    .mode       (mode),
    .abort      (abort),
    .seed       (seed),
    .q          (q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Behavioural RAM: synchronous write, registered read.
  logic [3:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_scan_q[$];
  logic [3:0] ref_mem [32];
  int         wren_cycles = 0;
  int         done_cnt    = 0;
  int         hold_cnt    = 0;
  int         min_hold    = 1000;
  logic       prev_valid  = 1'b0;
  logic [4:0] prev_addr   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: every write must match the next expected write.
  always @(negedge clk) begin
    logic [8:0] e;
    if (resetn === 1'b1 && wren === 1'b1) begin
      wren_cycles++;
      if (exp_q.size() == 0) check("write_unexpected", 32'(address), 32'hFFFF);
      else begin
        e = exp_q.pop_front();
        check("write", 32'({address, data}), 32'(e));
      end
    end
  end

  // Scan monitor: a newly displayed word is compared with the next expected word.
  always @(negedge clk) begin
    logic [8:0] e;
    if (scan_valid === 1'b1 && (!prev_valid || scan_addr != prev_addr)) begin
      if (prev_valid && hold_cnt < min_hold) min_hold = hold_cnt;
      hold_cnt = 1;
      if (exp_scan_q.size() == 0) check("scan_unexpected", 32'(scan_addr), 32'hFFFF);
      else begin
        e = exp_scan_q.pop_front();
        check("scan_word", 32'({scan_addr, scan_data}), 32'(e));
      end
    end else if (scan_valid === 1'b1) begin
      hold_cnt++;
    end
    prev_valid = (scan_valid === 1'b1);
    prev_addr  = scan_addr;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic m, input logic [3:0] s);
    @(posedge clk); #1;
    go = 1'b1; mode = m; seed = s;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic push_fill(input logic [3:0] s, input int last);
    for (int i = 0; i <= last; i++) begin
      exp_q.push_back({5'(i), 4'(s + 4'(i))});
      ref_mem[i] = 4'(s + 4'(i));
    end
  endtask

  task automatic push_scan(input int last);
    for (int i = 0; i <= last; i++) exp_scan_q.push_back({5'(i), ref_mem[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_address"},    32'(address),    32'd0);
    check({tag, "_data"},       32'(data),       32'd0);
    check({tag, "_wren"},       32'(wren),       32'd0);
    check({tag, "_scan_addr"},  32'(scan_addr),  32'd0);
    check({tag, "_scan_data"},  32'(scan_data),  32'd0);
    check({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_state"},      32'(dbg_state),  32'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic found;
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
    resetn = 1'b0; go = 1'b0; mode = 1'b0; abort = 1'b0; seed = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 resetn = 1'b1;

    // Fill with seed 3.
    push_fill(4'h3, 31);
    wren_cycles = 0;
    start_op(1'b0, 4'h3);
    wait_done(60, "fill1");
    check("fill1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("fill1_done_one_cycle", 32'(done), 32'd0);
    check("fill1_done_count", 32'(done_cnt), 32'd1);
    check("fill1_wren_cycles", 32'(wren_cycles), 32'd32);
    check("fill1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full scan of the seed-3 pattern.
    push_scan(31);
    start_op(1'b1, 4'h0);
    wait_done(300, "scan1");
    @(negedge clk);
    check("scan1_queue_empty", 32'(exp_scan_q.size()), 32'd0);
    check("scan1_done_count", 32'(done_cnt), 32'd2);
    check("scan1_hold_addr", 32'(scan_addr), 32'd31);
    check("scan1_hold_data", 32'(scan_data), 32'(ref_mem[31]));
    check("scan1_hold_valid", 32'(scan_valid), 32'd1);

    // Abort the fill at the write to address 10.
    push_fill(4'h5, 10);
    start_op(1'b0, 4'h5);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (address === 5'd10 && wren === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_addr10", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd2);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // Scan back: 0..10 hold the new pattern, 11..31 keep the seed-3 values.
    push_scan(31);
    start_op(1'b1, 4'h0);
    wait_done(300, "scan2");
    @(negedge clk);
    check("scan2_queue_empty", 32'(exp_scan_q.size()), 32'd0);

    // Reset while the display dwells on address 2.
    push_scan(2);
    start_op(1'b1, 4'h0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (scan_addr === 5'd2 && scan_valid === 1'b1 && dbg_state === 3'(SCAN_DWELL)) begin
        found = 1'b1; break;
      end
    end
    check("rst_reach_dwell", 32'(found), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("midscan_reset");
    check("rst_scan_queue", 32'(exp_scan_q.size()), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    push_scan(31);
    start_op(1'b1, 4'h0);
    wait_done(300, "rescan");
    @(negedge clk);
    check("rescan_queue_empty", 32'(exp_scan_q.size()), 32'd0);
    check("rescan_last_addr", 32'(scan_addr), 32'd31);

    // Hold go high: the second fill starts only after a return to IDLE.
    push_fill(4'h9, 31);
    push_fill(4'h9, 31);
    @(posedge clk); #1;
    go = 1'b1; mode = 1'b0; seed = 4'h9;
    wait_done(60, "gohold1");
    check("gohold_idle_between", 32'(busy), 32'd0);
    check("gohold_no_write_idle", 32'(wren), 32'd0);
    @(negedge clk);
    check("gohold_restart_busy", 32'(busy), 32'd1);
    check("gohold_restart_addr", 32'(address), 32'd0);
    go = 1'b0;
    wait_done(60, "gohold2");
    @(negedge clk);
    check("gohold_queue_empty", 32'(exp_q.size()), 32'd0);

    // abort together with go in IDLE: the block stays idle.
    @(posedge clk); #1;
    abort = 1'b1; go = 1'b1; mode = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_abort_busy", 32'(busy), 32'd0);
      check("idle_abort_state", 32'(dbg_state), 32'(IDLE));
    end
    abort = 1'b0; go = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_abort_no_write", 32'(exp_q.size()), 32'd0);

    check("total_done_count", 32'(done_cnt), 32'd6);
    check("scan_hold_min", 32'(min_hold >= DWELL && min_hold < 1000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
